// File: rtl/phase_acc_scheduler.sv
// phase_acc_scheduler
// Shares one external 32-bit adder across NUM_VOICES phase accumulators.
// Each sample tick sweeps the voices in ascending order, one add per clock,
// writing phase[v] + tune[v] back and presenting the result downstream.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | adder operands forced to 0, waiting for sample_tick
// RUN   | idx selects the voice on the adder; result registered at edge
module phase_acc_scheduler #(
  parameter  int NUM_VOICES = 8,
  localparam int VW         = $clog2(NUM_VOICES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_tick,
  input  logic          cfg_we,
  input  logic          cfg_phase_clr,
  input  logic [VW-1:0] cfg_voice,
  input  logic [31:0]   cfg_word,
  output logic [31:0]   add_a,
  output logic [31:0]   add_b,
  output logic          add_cin,
  input  logic [31:0]   add_sum,
  input  logic          add_cout,
  output logic          phase_valid,
  output logic [31:0]   phase_out,
  output logic [VW-1:0] phase_voice,
  output logic          wrap,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [VW-1:0] LAST_IDX = VW'(NUM_VOICES - 1);

  state_t        state;
  state_t        state_nxt;
  logic [VW-1:0] idx;
  logic [VW-1:0] idx_nxt;
  logic [31:0]   phase [NUM_VOICES];
  logic [31:0]   tune  [NUM_VOICES];
  logic          run;
  logic          last;

  assign run     = (state == RUN);
  assign last    = run && (idx == LAST_IDX);
  assign busy    = run;
  assign add_cin = 1'b0;

  // Operands are zeroed in IDLE so the shared adder sees no activity.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (run) begin
      add_a = phase[idx];
      add_b = tune[idx];
    end
  end

  // Next-state and voice-index sequencing; ticks during RUN are not queued.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (sample_tick) begin
          state_nxt = RUN;
          idx_nxt   = '0;
        end
      end
      RUN: begin
        if (idx == LAST_IDX) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end

  // State and index registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Per-voice phase/tune storage; a phase clear overrides a same-cycle
  // write-back, and a tune write only affects the next read of that voice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase[v] <= '0;
        tune[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (cfg_phase_clr && (cfg_voice == VW'(v))) begin
          phase[v] <= '0;
        end else if (run && (idx == VW'(v))) begin
          phase[v] <= add_sum;
        end
        if (cfg_we && (cfg_voice == VW'(v))) begin
          tune[v] <= cfg_word;
        end
      end
    end
  end

  // Registered result port to the waveform stage, plus sticky overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_valid <= 1'b0;
      phase_out   <= '0;
      phase_voice <= '0;
      wrap        <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      phase_valid <= run;
      done        <= last;
      if (run) begin
        phase_out   <= add_sum;
        phase_voice <= idx;
        wrap        <= add_cout;
      end
      if (run && sample_tick) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_acc_scheduler.sv
// Directed bench for phase_acc_scheduler with a behavioural 32-bit adder.
module tb_phase_acc_scheduler;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic        cfg_we;
  logic        cfg_phase_clr;
  logic [2:0]  cfg_voice;
  logic [31:0] cfg_word;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        phase_valid;
  logic [31:0] phase_out;
  logic [2:0]  phase_voice;
  logic        wrap;
  logic        busy;
  logic        done;
  logic        overrun;

  logic [32:0] sum33;
  assign sum33    = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
  assign add_sum  = sum33[31:0];
  assign add_cout = sum33[32];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_out  [N];
  logic        exp_wrap [N];

  phase_acc_scheduler #(.NUM_VOICES(N)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_tick  (sample_tick),
    .cfg_we       (cfg_we),
    .cfg_phase_clr(cfg_phase_clr),
    .cfg_voice    (cfg_voice),
    .cfg_word     (cfg_word),
    .add_a        (add_a),
    .add_b        (add_b),
    .add_cin      (add_cin),
    .add_sum      (add_sum),
    .add_cout     (add_cout),
    .phase_valid  (phase_valid),
    .phase_out    (phase_out),
    .phase_voice  (phase_voice),
    .wrap         (wrap),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_lin(input int m);
    for (int v = 0; v < N; v++) begin
      exp_out[v]  = 32'(m * (v + 1));
      exp_wrap[v] = 1'b0;
    end
  endtask

  // Tick in the current cycle (cycle 0) and check the whole sweep timing.
  // Optional cfg_we / cfg_phase_clr pulses are driven in the given cycles.
  task automatic do_sweep(input string tag, input int we_cyc, input int we_v,
                          input logic [31:0] we_w, input int clr_cyc, input int clr_v);
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      chk($sformatf("%s busy c%0d", tag, c), {31'b0, busy}, {31'b0, c <= N});
      chk($sformatf("%s done c%0d", tag, c), {31'b0, done}, {31'b0, c == N + 1});
      chk($sformatf("%s valid c%0d", tag, c), {31'b0, phase_valid}, {31'b0, c >= 2});
      if (c >= 2) begin
        chk($sformatf("%s voice c%0d", tag, c), {29'b0, phase_voice}, 32'(c - 2));
        chk($sformatf("%s out v%0d", tag, c - 2), phase_out, exp_out[c-2]);
        chk($sformatf("%s wrap v%0d", tag, c - 2), {31'b0, wrap}, {31'b0, exp_wrap[c-2]});
      end
      cfg_we        = (c == we_cyc);
      cfg_phase_clr = (c == clr_cyc);
      cfg_voice     = (c == clr_cyc) ? 3'(clr_v) : 3'(we_v);
      cfg_word      = we_w;
      step();
    end
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;
    chk({tag, " idle busy"}, {31'b0, busy}, 32'd0);
    chk({tag, " idle valid"}, {31'b0, phase_valid}, 32'd0);
    chk({tag, " idle done"}, {31'b0, done}, 32'd0);
    chk({tag, " idle add_a"}, add_a, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    sample_tick   = 1'b0;
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;
    cfg_voice     = '0;
    cfg_word      = '0;
    repeat (3) step();

    chk("rst valid", {31'b0, phase_valid}, 32'd0);
    chk("rst out", phase_out, 32'd0);
    chk("rst voice", {29'b0, phase_voice}, 32'd0);
    chk("rst wrap", {31'b0, wrap}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst overrun", {31'b0, overrun}, 32'd0);
    chk("rst add_a", add_a, 32'd0);
    chk("rst add_b", add_b, 32'd0);
    chk("rst add_cin", {31'b0, add_cin}, 32'd0);
    rst_n = 1'b1;
    step();

    // tune[v] = v+1
    for (int v = 0; v < N; v++) begin
      cfg_we    = 1'b1;
      cfg_voice = 3'(v);
      cfg_word  = 32'(v + 1);
      step();
    end
    cfg_we = 1'b0;
    chk("cfg idle add_b", add_b, 32'd0);

    set_lin(1);
    do_sweep("basic1", -1, 0, 32'd0, -1, 0);
    set_lin(2);
    do_sweep("basic2", -1, 0, 32'd0, -1, 0);

    // Voice 3: clear phase and load half-scale tune in the same cycle.
    cfg_we        = 1'b1;
    cfg_phase_clr = 1'b1;
    cfg_voice     = 3'd3;
    cfg_word      = 32'h8000_0000;
    step();
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;

    set_lin(3);
    exp_out[3] = 32'h8000_0000;
    do_sweep("wrap1", -1, 0, 32'd0, -1, 0);
    set_lin(4);
    exp_out[3]  = 32'h0000_0000;
    exp_wrap[3] = 1'b1;
    do_sweep("wrap2", -1, 0, 32'd0, -1, 0);
    chk("pre overrun", {31'b0, overrun}, 32'd0);

    // Overrun: tick in cycle 0, rejected tick in cycle 4, accepted in cycle 9.
    set_lin(5);
    exp_out[3] = 32'h8000_0000;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      chk($sformatf("ovr busy c%0d", c), {31'b0, busy}, {31'b0, c <= N});
      chk($sformatf("ovr flag c%0d", c), {31'b0, overrun}, {31'b0, c >= 5});
      chk($sformatf("ovr done c%0d", c), {31'b0, done}, {31'b0, c == N + 1});
      if (c >= 2) begin
        chk($sformatf("ovr voice c%0d", c), {29'b0, phase_voice}, 32'(c - 2));
        chk($sformatf("ovr out v%0d", c - 2), phase_out, exp_out[c-2]);
      end
      if (c <= N) begin
        sample_tick = (c == 4);
        step();
      end
    end
    sample_tick = 1'b0;

    set_lin(6);
    exp_out[3]  = 32'h0000_0000;
    exp_wrap[3] = 1'b1;
    do_sweep("after_ovr", -1, 0, 32'd0, -1, 0);
    chk("overrun held", {31'b0, overrun}, 32'd1);

    // Collision setup: phase[2]=0, tune[2]=0x10.
    cfg_we        = 1'b1;
    cfg_phase_clr = 1'b1;
    cfg_voice     = 3'd2;
    cfg_word      = 32'h10;
    step();
    cfg_we        = 1'b0;
    cfg_phase_clr = 1'b0;

    set_lin(7);
    exp_out[2] = 32'h10;
    exp_out[3] = 32'h8000_0000;
    do_sweep("coll1", 3, 2, 32'h100, 6, 5);
    set_lin(8);
    exp_out[2]  = 32'h110;
    exp_out[3]  = 32'h0000_0000;
    exp_wrap[3] = 1'b1;
    exp_out[5]  = 32'd6;
    do_sweep("coll2", -1, 0, 32'd0, -1, 0);
    chk("overrun still held", {31'b0, overrun}, 32'd1);

    // Reset mid-sweep for 3 cycles.
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    repeat (3) step();
    chk("mid busy", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    repeat (3) step();
    chk("mrst valid", {31'b0, phase_valid}, 32'd0);
    chk("mrst out", phase_out, 32'd0);
    chk("mrst voice", {29'b0, phase_voice}, 32'd0);
    chk("mrst wrap", {31'b0, wrap}, 32'd0);
    chk("mrst busy", {31'b0, busy}, 32'd0);
    chk("mrst done", {31'b0, done}, 32'd0);
    chk("mrst overrun", {31'b0, overrun}, 32'd0);
    chk("mrst add_a", add_a, 32'd0);
    rst_n = 1'b1;
    step();

    // Only voice 0 retuned; others keep the reset tune of 0.
    cfg_we    = 1'b1;
    cfg_voice = 3'd0;
    cfg_word  = 32'h1234;
    step();
    cfg_we = 1'b0;
    set_lin(0);
    exp_out[0] = 32'h1234;
    do_sweep("post_rst", -1, 0, 32'd0, -1, 0);
    chk("post_rst overrun", {31'b0, overrun}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
